// File: rtl/sc_stream_to_binary.sv
// sc_stream_to_binary
// Dual-channel stochastic-to-binary converter. It counts the ones on two
// unipolar bitstreams over a window of 2**WIN_LOG valid samples. Each count
// is presented as an unsigned Q0.N fraction. A count equal to the full
// window length saturates to all ones and raises the matching sat flag.
module sc_stream_to_binary #(
    parameter int unsigned N       = 16,
    parameter int unsigned WIN_LOG = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         bit_valid,
    input  logic         bit_a,
    input  logic         bit_b,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a_val,
    output logic [N-1:0] b_val,
    output logic         sat_a,
    output logic         sat_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIN_LOG:0] CNT_ZERO = '0;
    localparam logic [WIN_LOG:0] CNT_ONE  = {{WIN_LOG{1'b0}}, 1'b1};
    // Sample index of the final sample in a window (L-1)
    localparam logic [WIN_LOG:0] LAST_SMP = {1'b0, {WIN_LOG{1'b1}}};

    state_t           state_q, state_d;
    logic [WIN_LOG:0] cnt_a_q, cnt_a_d;
    logic [WIN_LOG:0] cnt_b_q, cnt_b_d;
    logic [WIN_LOG:0] smp_q, smp_d;
    logic [N-1:0]     a_val_q, a_val_d;
    logic [N-1:0]     b_val_q, b_val_d;
    logic             sat_a_q, sat_a_d;
    logic             sat_b_q, sat_b_d;

    logic [WIN_LOG:0] sum_a;
    logic [WIN_LOG:0] sum_b;

    // Count c in 0..L becomes c << (N-WIN_LOG); c == L saturates to all ones.
    function automatic logic [N-1:0] to_frac(input logic [WIN_LOG:0] c);
        logic [N-1:0] v;
        v = '0;
        if (c[WIN_LOG]) begin
            v = '1;
        end else begin
            v[N-1 -: WIN_LOG] = c[WIN_LOG-1:0];
        end
        return v;
    endfunction

    // Running counts including the sample presented this cycle, so the
    // final sample can be folded into the result on the same edge.
    always_comb begin
        sum_a = cnt_a_q + {{WIN_LOG{1'b0}}, bit_a};
        sum_b = cnt_b_q + {{WIN_LOG{1'b0}}, bit_b};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            smp_q   <= '0;
            a_val_q <= '0;
            b_val_q <= '0;
            sat_a_q <= 1'b0;
            sat_b_q <= 1'b0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            smp_q   <= smp_d;
            a_val_q <= a_val_d;
            b_val_q <= b_val_d;
            sat_a_q <= sat_a_d;
            sat_b_q <= sat_b_d;
        end
    end

    // Next-state, counter and result-load logic
    always_comb begin
        state_d = state_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        smp_d   = smp_q;
        a_val_d = a_val_q;
        b_val_d = b_val_q;
        sat_a_d = sat_a_q;
        sat_b_d = sat_b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_a_d = CNT_ZERO;
                    cnt_b_d = CNT_ZERO;
                    smp_d   = CNT_ZERO;
                end
            end

            ACCUM: begin
                if (bit_valid) begin
                    cnt_a_d = sum_a;
                    cnt_b_d = sum_b;
                    smp_d   = smp_q + CNT_ONE;
                    if (smp_q == LAST_SMP) begin
                        state_d = HOLD;
                        a_val_d = to_frac(sum_a);
                        b_val_d = to_frac(sum_b);
                        sat_a_d = sum_a[WIN_LOG];
                        sat_b_d = sum_b[WIN_LOG];
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        cnt_a_d = CNT_ZERO;
                        cnt_b_d = CNT_ZERO;
                        smp_d   = CNT_ZERO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign a_val     = a_val_q;
    assign b_val     = b_val_q;
    assign sat_a     = sat_a_q;
    assign sat_b     = sat_b_q;

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Scoreboard bench for sc_stream_to_binary with N=8, WIN_LOG=4 (L=16).
// Stimulus pushes hand-computed results; a monitor pops on each handshake.
module tb_sc_stream_to_binary;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       bit_valid;
    logic       bit_a;
    logic       bit_b;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic       sat_a;
    logic       sat_b;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sa;
        logic       sb;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    sc_stream_to_binary #(.N(8), .WIN_LOG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_a     (bit_a),
        .bit_b     (bit_b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_val     (a_val),
        .b_val     (b_val),
        .sat_a     (sat_a),
        .sat_b     (sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next edge
    task automatic cyc(input logic s, input logic v, input logic a, input logic b, input logic r);
        start     = s;
        bit_valid = v;
        bit_a     = a;
        bit_b     = b;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Feed 16 valid samples, with optional stall run before sample stall_at
    // and an optional start pulse on sample 8.
    task automatic accum(input logic [15:0] pa, input logic [15:0] pb, input int stall_at,
                         input int stall_n, input logic rdy, input logic pulse8);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) cyc(1'b0, 1'b0, 1'b1, 1'b1, rdy);
            end
            if (i == 15) begin
                chk("busy_before_last", 32'(busy), 32'd1);
                chk("no_valid_before_last", 32'(out_valid), 32'd0);
            end
            cyc(pulse8 && (i == 8), 1'b1, pa[i], pb[i], rdy);
        end
        chk("valid_after_window", 32'(out_valid), 32'd1);
        chk("busy_clear_in_hold", 32'(busy), 32'd0);
    endtask

    // Monitor: compare against the scoreboard on every accepted result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_a_val", 32'(a_val), 32'(e.a));
                chk("sb_b_val", 32'(b_val), 32'(e.b));
                chk("sb_sat_a", 32'(sat_a), 32'(e.sa));
                chk("sb_sat_b", 32'(sat_b), 32'(e.sb));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; bit_valid = 1'b0; bit_a = 1'b0; bit_b = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_val", 32'(a_val), 32'd0);
        chk("rst_b_val", 32'(b_val), 32'd0);
        chk("rst_sat_a", 32'(sat_a), 32'd0);
        chk("rst_sat_b", 32'(sat_b), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full scale on A, zero on B
        sb_q.push_back('{a: 8'hFF, b: 8'h00, sa: 1'b1, sb: 1'b0});
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        accum(16'hFFFF, 16'h0000, -1, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_after_hs_valid", 32'(out_valid), 32'd0);
        chk("idle_after_hs_busy", 32'(busy), 32'd0);
        chk("a_val_kept_after_hs", 32'(a_val), 32'hFF);

        // Half and quarter
        sb_q.push_back('{a: 8'h80, b: 8'h40, sa: 1'b0, sb: 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        accum(16'h5555, 16'h8888, -1, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("half_idle_valid", 32'(out_valid), 32'd0);
        chk("half_idle_busy", 32'(busy), 32'd0);

        // Stall of 5 cycles mid-window: result appears at cycle 22
        sb_q.push_back('{a: 8'hFF, b: 8'h00, sa: 1'b1, sb: 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        accum(16'hFFFF, 16'h0000, 8, 5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stalled ones are not counted: 3 valid ones -> 0x30
        sb_q.push_back('{a: 8'h30, b: 8'h00, sa: 1'b0, sb: 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        accum(16'h0007, 16'h0000, 8, 5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure in HOLD, then back-to-back start on the handshake
        sb_q.push_back('{a: 8'h50, b: 8'hC0, sa: 1'b0, sb: 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        accum(16'h001F, 16'h0FFF, -1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'(k % 2), 1'b1, 1'(k % 2), 1'b0, 1'b0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd0);
            chk("bp_a_val", 32'(a_val), 32'h50);
            chk("bp_b_val", 32'(b_val), 32'hC0);
        end
        sb_q.push_back('{a: 8'h00, b: 8'hFF, sa: 1'b0, sb: 1'b1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_out_valid", 32'(out_valid), 32'd0);
        accum(16'h0000, 16'hFFFF, -1, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset after 7 samples
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_b_val", 32'(b_val), 32'd0);
        chk("arst_sat_b", 32'(sat_b), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        sb_q.push_back('{a: 8'h00, b: 8'h00, sa: 1'b0, sb: 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        accum(16'h0000, 16'h0000, -1, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start pulse inside ACCUM has no effect
        sb_q.push_back('{a: 8'h70, b: 8'hA0, sa: 1'b0, sb: 1'b0});
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        accum(16'h007F, 16'h03FF, -1, 0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_to_binary.md
# sc_stream_to_binary

Dual-channel stochastic-to-binary converter. It counts the ones in two unipolar stochastic bitstreams over a fixed window of 2^WIN_LOG valid samples. It emits each count as an N-bit unsigned Q0.N fraction. It sits directly upstream of the team's N×N gate-level multiplier and supplies both operands, so that a stochastic product can be checked against the exact binary product.

## Interface
- N, 16, output width; each result is Q0.N (all bits fractional)
- WIN_LOG, 16, log2 of window length in valid samples; legal range 1..N

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a new conversion window
- bit_valid  input  1  bit_a/bit_b carry a sample this cycle
- bit_a  input  1  stochastic bitstream, channel A
- bit_b  input  1  stochastic bitstream, channel B
- busy  output  1  window in progress (state ACCUM)
- out_valid  output  1  a_val/b_val/sat_a/sat_b hold a completed result
- out_ready  input  1  consumer accepts result
- a_val  output  N  channel A result, Q0.N
- b_val  output  N  channel B result, Q0.N
- sat_a  output  1  channel A count hit full scale and was saturated
- sat_b  output  1  channel B count hit full scale and was saturated

## Operation
- Window length L = 2^WIN_LOG valid samples.
- Internal counters:
  - cnt_a, cnt_b: WIN_LOG+1 bits.
  - sample counter: WIN_LOG+1 bits.
- FSM states IDLE, ACCUM, HOLD; reset state IDLE.
- IDLE:
  - start=1 → ACCUM; clear cnt_a, cnt_b and the sample counter.
  - The start cycle's bits are not sampled.
- ACCUM:
  - Each cycle with bit_valid=1, the sample counter increments and cnt_a/cnt_b add bit_a/bit_b.
  - bit_valid=0 freezes all counters (stall); there is no timeout.
  - On the cycle the L-th valid sample is taken → HOLD, and the result registers load in the same edge, including that sample.
  - start is ignored in ACCUM.
- Result conversion (per channel, count c in 0..L):
  - c < L: val = c << (N−WIN_LOG), lower bits zero, sat=0.
  - c = L: val = 2^N−1 (all ones), sat=1.
- HOLD:
  - out_valid=1.
  - a_val, b_val, sat_a and sat_b stay stable until the handshake.
  - On out_valid & out_ready: if start=1 in the same cycle → ACCUM with counters cleared (back-to-back); otherwise → IDLE.
  - start without out_ready is ignored.
- After the handshake, result registers keep their last values; only out_valid qualifies them.
- bit_a/bit_b are don't-care when bit_valid=0 or when the state is not ACCUM.

## Timing
- Reset (rst_n=0, asynchronous):
  - State → IDLE.
  - busy=0, out_valid=0, a_val=0, b_val=0, sat_a=0, sat_b=0.
  - All counters 0.
- Reset mid-ACCUM or mid-HOLD aborts the window; no result is produced; the released state is IDLE.
- Start at cycle 0 with bit_valid=1 continuously:
  - Samples are taken in cycles 1..L.
  - busy=1 in cycles 1..L.
  - out_valid=1 from cycle L+1.
  - Latency is L+1 cycles plus the number of stalled cycles.
- The earliest accepted next start is the handshake cycle itself, which gives a gap of zero idle cycles between windows.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: N=8, WIN_LOG=4, L=16.

- Full-scale and zero: start, 16 cycles with bit_a=1 and bit_b=0, bit_valid=1, out_ready=1 → out_valid at cycle 17; a_val=0xFF, sat_a=1, b_val=0x00, sat_b=0.
- Half and quarter: bit_a alternating 1,0; bit_b=1 every 4th sample → a_val=0x80, b_val=0x40, sat flags 0; handshake returns the FSM to IDLE next cycle.
- Stall: same stimulus as the full-scale/zero scenario but bit_valid=0 for 5 cycles mid-window with bit_a=1 during the stalls → out_valid at cycle 22; a_val=0xFF, sat_a=1; the stalled bits are not counted (check with bit_a=0 on valid samples: 3 ones gives a_val=0x30).
- Backpressure then back-to-back: hold out_ready=0 for 10 cycles in HOLD, toggling start and bit_a → a_val/b_val unchanged, out_valid=1, busy=0. Then out_ready=1 with start=1 → next cycle busy=1, a fresh window runs, and its result is independent of the first.
- Reset mid-window: assert rst_n=0 after 7 samples → outputs 0 immediately and asynchronously. Release and start a new window of all-zeros → a_val=0x00, proving the counters were cleared.
- Start ignored: pulse start during ACCUM at sample 8 → window completes at the original cycle with no restart.
